// File: rtl/fir_coeff_reload_ctrl_pkg.sv
// Shared types and width helpers for the FIR coefficient reload sequencer.
package fir_coeff_reload_ctrl_pkg;

    typedef enum logic [2:0] {
        UNCONF = 3'd0,
        RUN    = 3'd1,
        DRAIN  = 3'd2,
        LOAD   = 3'd3,
        FLUSH  = 3'd4
    } state_t;

    localparam int DEF_COEFF_WIDTH = 18;
    localparam int DEF_DATA_WIDTH  = 18;

    // A single-entry bank still needs one address bit on the port.
    function automatic int addr_width(input int coeff_count);
        return (coeff_count > 1) ? $clog2(coeff_count) : 1;
    endfunction

    // Width able to hold the value max_value itself.
    function automatic int cnt_width(input int max_value);
        return $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/fir_coeff_shadow_bank.sv
// Shadow coefficient register file: one write port, one combinational read port.
module fir_coeff_shadow_bank
    import fir_coeff_reload_ctrl_pkg::*;
#(
    parameter int Count = 16,
    parameter int Width = DEF_COEFF_WIDTH,
    localparam int AddrW = addr_width(Count)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [AddrW-1:0] i_wr_addr,
    input  logic [Width-1:0] i_wr_data,
    input  logic [AddrW-1:0] i_rd_addr,
    output logic [Width-1:0] o_rd_data
);

    logic [Width-1:0] r_mem [Count];

    // Synchronous clear, otherwise capture host writes.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < Count; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fir_coeff_reload_ctrl.sv
// Sequencer in front of the symmetric FIR: owns sample and coefficient ports,
// reloads coefficients on commit and hides the flush results from downstream.
//
// state  | meaning
// UNCONF | after reset, filter holds no valid coefficients, no samples accepted
// RUN    | samples forwarded to filter, results forwarded downstream
// DRAIN  | commit seen, waiting for in-flight results and pending discards
// LOAD   | copying shadow[k] into filter, k = 0..CoeffCount-1
// FLUSH  | injecting FlushLen zero samples to clear the delay line
module fir_coeff_reload_ctrl
    import fir_coeff_reload_ctrl_pkg::*;
#(
    parameter int CoeffCount  = 16,
    parameter int CoeffWidth  = DEF_COEFF_WIDTH,
    parameter int DataWidth   = DEF_DATA_WIDTH,
    parameter int FlushLen    = 32,
    parameter int MaxInFlight = 64,
    localparam int AddrW  = addr_width(CoeffCount),
    localparam int CntW   = cnt_width(MaxInFlight),
    localparam int FlushW = cnt_width(FlushLen)
) (
    input  logic                  Clk_i,
    input  logic                  Rst_i,
    input  logic [DataWidth-1:0]  Data_i,
    input  logic                  DataNd_i,
    output logic                  Ready_o,
    input  logic [CoeffWidth-1:0] CoeffWrData_i,
    input  logic [AddrW-1:0]      CoeffWrAddr_i,
    input  logic                  CoeffWrEn_i,
    input  logic                  Commit_i,
    output logic                  Busy_o,
    output logic [DataWidth-1:0]  FiltData_o,
    output logic                  FiltDataNd_o,
    output logic [CoeffWidth-1:0] FiltCoeffData_o,
    output logic [AddrW-1:0]      FiltCoeffAddr_o,
    output logic                  FiltCoeffWe_o,
    input  logic [DataWidth-1:0]  FiltOut_i,
    input  logic                  FiltOutValid_i,
    output logic [DataWidth-1:0]  Data_o,
    output logic                  DataValid_o,
    output logic                  DropErr_o
);

    state_t r_state;
    state_t w_state_nxt;

    logic [AddrW-1:0]      r_load_idx;
    logic [FlushW-1:0]     r_flush_cnt;
    logic [FlushW-1:0]     r_disc_cnt;
    logic [CntW-1:0]       r_pend_cnt;
    logic                  r_filt_nd;
    logic [DataWidth-1:0]  r_filt_data;
    logic                  r_data_valid;
    logic [DataWidth-1:0]  r_data;
    logic                  r_drop_err;

    logic                  w_ready;
    logic                  w_busy;
    logic                  w_accept;
    logic                  w_result;
    logic                  w_discard;
    logic                  w_load_last;
    logic                  w_flush_last;
    logic                  w_shadow_we;
    logic [CoeffWidth-1:0] w_shadow_rd;

    assign w_load_last  = (r_load_idx == AddrW'(CoeffCount - 1));
    assign w_flush_last = (r_flush_cnt == '0);
    assign w_accept     = w_ready && DataNd_i;
    assign w_discard    = FiltOutValid_i && (r_disc_cnt != '0);
    assign w_result     = FiltOutValid_i && (r_disc_cnt == '0);
    // Busy is decoded from the current state, so a write in the commit cycle still lands.
    assign w_shadow_we  = CoeffWrEn_i && !w_busy;

    fir_coeff_shadow_bank #(
        .Count (CoeffCount),
        .Width (CoeffWidth)
    ) u_shadow (
        .i_clk     (Clk_i),
        .i_rst_n   (Rst_i),
        .i_wr_en   (w_shadow_we),
        .i_wr_addr (CoeffWrAddr_i),
        .i_wr_data (CoeffWrData_i),
        .i_rd_addr (r_load_idx),
        .o_rd_data (w_shadow_rd)
    );

    // State register.
    always_ff @(posedge Clk_i) begin
        if (!Rst_i) begin
            r_state <= UNCONF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            UNCONF: begin
                if (Commit_i) w_state_nxt = LOAD;
            end
            RUN: begin
                w_ready = 1'b1;
                if (Commit_i) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                w_busy = 1'b1;
                if (r_pend_cnt == '0 && r_disc_cnt == '0) w_state_nxt = LOAD;
            end
            LOAD: begin
                w_busy = 1'b1;
                if (w_load_last) w_state_nxt = FLUSH;
            end
            FLUSH: begin
                w_busy = 1'b1;
                if (w_flush_last) w_state_nxt = RUN;
            end
            default: w_state_nxt = UNCONF;
        endcase
    end

    // Load index walks up the bank; flush timer is preset during LOAD and counts down.
    always_ff @(posedge Clk_i) begin
        if (!Rst_i) begin
            r_load_idx  <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_state == LOAD && !w_load_last) r_load_idx <= r_load_idx + AddrW'(1);
            else                                 r_load_idx <= '0;
            if (r_state == LOAD)                      r_flush_cnt <= FlushW'(FlushLen - 1);
            else if (r_state == FLUSH && !w_flush_last) r_flush_cnt <= r_flush_cnt - FlushW'(1);
        end
    end

    // Discard counter swallows one result per flush sample; pending tracks real samples.
    always_ff @(posedge Clk_i) begin
        if (!Rst_i) begin
            r_disc_cnt <= '0;
            r_pend_cnt <= '0;
        end else begin
            if (r_state == LOAD && w_load_last) r_disc_cnt <= FlushW'(FlushLen);
            else if (w_discard)                 r_disc_cnt <= r_disc_cnt - FlushW'(1);
            case ({w_accept, w_result})
                2'b10:   r_pend_cnt <= r_pend_cnt + CntW'(1);
                2'b01:   r_pend_cnt <= r_pend_cnt - CntW'(1);
                default: r_pend_cnt <= r_pend_cnt;
            endcase
        end
    end

    // Sample path to the filter, result path downstream, sticky drop flag.
    always_ff @(posedge Clk_i) begin
        if (!Rst_i) begin
            r_filt_nd    <= 1'b0;
            r_filt_data  <= '0;
            r_data_valid <= 1'b0;
            r_data       <= '0;
            r_drop_err   <= 1'b0;
        end else begin
            r_filt_nd    <= w_accept;
            if (w_accept) r_filt_data <= Data_i;
            r_data_valid <= w_result;
            if (w_result) r_data <= FiltOut_i;
            if (DataNd_i && !w_ready) r_drop_err <= 1'b1;
        end
    end

    assign Ready_o         = w_ready;
    assign Busy_o          = w_busy;
    assign FiltDataNd_o    = r_filt_nd || (r_state == FLUSH);
    assign FiltData_o      = (r_state == FLUSH) ? '0 : r_filt_data;
    assign FiltCoeffWe_o   = (r_state == LOAD);
    assign FiltCoeffAddr_o = r_load_idx;
    assign FiltCoeffData_o = (r_state == LOAD) ? w_shadow_rd : '0;
    assign Data_o          = r_data;
    assign DataValid_o     = r_data_valid;
    assign DropErr_o       = r_drop_err;

endmodule

// File: tb/tb_fir_coeff_reload_ctrl.sv
// Directed bench for the FIR coefficient reload sequencer with a 20-cycle echo filter model.
module tb_fir_coeff_reload_ctrl;

    localparam int LAT = 20;

    logic        clk;
    logic        Rst_i;
    logic [17:0] Data_i;
    logic        DataNd_i;
    logic        Ready_o;
    logic [17:0] CoeffWrData_i;
    logic [3:0]  CoeffWrAddr_i;
    logic        CoeffWrEn_i;
    logic        Commit_i;
    logic        Busy_o;
    logic [17:0] FiltData_o;
    logic        FiltDataNd_o;
    logic [17:0] FiltCoeffData_o;
    logic [3:0]  FiltCoeffAddr_o;
    logic        FiltCoeffWe_o;
    logic [17:0] FiltOut_i;
    logic        FiltOutValid_i;
    logic [17:0] Data_o;
    logic        DataValid_o;
    logic        DropErr_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int load_start_cyc = 0;
    logic [17:0] exp_shadow [16];
    logic [17:0] exp_q [$];
    logic [17:0] got_q [$];
    int          got_cyc_q [$];

    fir_coeff_reload_ctrl dut (
        .Clk_i           (clk),
        .Rst_i           (Rst_i),
        .Data_i          (Data_i),
        .DataNd_i        (DataNd_i),
        .Ready_o         (Ready_o),
        .CoeffWrData_i   (CoeffWrData_i),
        .CoeffWrAddr_i   (CoeffWrAddr_i),
        .CoeffWrEn_i     (CoeffWrEn_i),
        .Commit_i        (Commit_i),
        .Busy_o          (Busy_o),
        .FiltData_o      (FiltData_o),
        .FiltDataNd_o    (FiltDataNd_o),
        .FiltCoeffData_o (FiltCoeffData_o),
        .FiltCoeffAddr_o (FiltCoeffAddr_o),
        .FiltCoeffWe_o   (FiltCoeffWe_o),
        .FiltOut_i       (FiltOut_i),
        .FiltOutValid_i  (FiltOutValid_i),
        .Data_o          (Data_o),
        .DataValid_o     (DataValid_o),
        .DropErr_o       (DropErr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Filter model: every sample strobe yields one result LAT cycles later, value = sample + 100.
    bit          pipe_v [LAT];
    bit [17:0]   pipe_d [LAT];
    always @(posedge clk) begin
        pipe_v[0] <= FiltDataNd_o;
        pipe_d[0] <= FiltData_o;
        for (int i = 1; i < LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign FiltOutValid_i = pipe_v[LAT-1];
    assign FiltOut_i      = pipe_d[LAT-1] + 18'd100;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (DataValid_o === 1'b1) begin
            got_q.push_back(Data_o);
            got_cyc_q.push_back(cyc);
        end
    endtask

    task automatic idle(input int n);
        int bad;
        bad = 0;
        repeat (n) begin
            tick();
            if (FiltCoeffWe_o !== 1'b0 || Busy_o !== 1'b0 || Ready_o !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_run: %0d bad cycles, want 0 (no load, Busy_o=0, Ready_o=1)", bad);
        end
    endtask

    // Waits for the load, checks every coefficient and flush strobe, optionally
    // offers a sample during LOAD or a second commit during FLUSH.
    task automatic watch_reload(input int drop_at, input int recommit_at);
        int n;
        n = 0;
        while (FiltCoeffWe_o !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL load_start: no FiltCoeffWe_o within 300 cycles");
            return;
        end
        load_start_cyc = cyc;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (FiltCoeffWe_o !== 1'b1 || FiltCoeffAddr_o !== 4'(k) ||
                FiltCoeffData_o !== exp_shadow[k] || Busy_o !== 1'b1 || Ready_o !== 1'b0) begin
                errors++;
                $display("FAIL coeff_%0d: we=%0b addr=%0d data=%h busy=%0b ready=%0b, want 1 %0d %h 1 0",
                         k, FiltCoeffWe_o, FiltCoeffAddr_o, FiltCoeffData_o, Busy_o, Ready_o,
                         k, exp_shadow[k]);
            end
            if (k == drop_at) begin
                DataNd_i = 1'b1;
                Data_i   = 18'h3ABCD;
            end
            tick();
            DataNd_i = 1'b0;
            if (k == drop_at) begin
                checks++;
                if (FiltDataNd_o !== 1'b0 || DropErr_o !== 1'b1) begin
                    errors++;
                    $display("FAIL drop_in_load: FiltDataNd_o=%0b DropErr_o=%0b, want 0 1",
                             FiltDataNd_o, DropErr_o);
                end
            end
        end
        for (int f = 0; f < 32; f++) begin
            checks++;
            if (FiltDataNd_o !== 1'b1 || FiltData_o !== 18'd0 || Busy_o !== 1'b1 ||
                FiltCoeffWe_o !== 1'b0) begin
                errors++;
                $display("FAIL flush_%0d: nd=%0b data=%h busy=%0b we=%0b, want 1 0 1 0",
                         f, FiltDataNd_o, FiltData_o, Busy_o, FiltCoeffWe_o);
            end
            if (f == recommit_at) Commit_i = 1'b1;
            tick();
            Commit_i = 1'b0;
        end
        checks++;
        if (Ready_o !== 1'b1 || Busy_o !== 1'b0 || FiltDataNd_o !== 1'b0) begin
            errors++;
            $display("FAIL run_entry: ready=%0b busy=%0b nd=%0b, want 1 0 0",
                     Ready_o, Busy_o, FiltDataNd_o);
        end
    endtask

    task automatic test_reset();
        Rst_i = 1'b0; Data_i = '0; DataNd_i = 1'b0; CoeffWrData_i = '0; CoeffWrAddr_i = '0;
        CoeffWrEn_i = 1'b0; Commit_i = 1'b0;
        for (int k = 0; k < 16; k++) exp_shadow[k] = '0;
        repeat (3) tick();
        checks++;
        if (Ready_o !== 1'b0 || Busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: ready=%0b busy=%0b, want 0 0", Ready_o, Busy_o);
        end
        checks++;
        if (FiltCoeffWe_o !== 1'b0 || FiltDataNd_o !== 1'b0 || DataValid_o !== 1'b0 || DropErr_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: we=%0b nd=%0b valid=%0b drop=%0b, want 0 0 0 0",
                     FiltCoeffWe_o, FiltDataNd_o, DataValid_o, DropErr_o);
        end
        checks++;
        if (Data_o !== 18'd0 || FiltData_o !== 18'd0 || FiltCoeffData_o !== 18'd0 || FiltCoeffAddr_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_data: data=%h fdata=%h cdata=%h caddr=%0d, want 0 0 0 0",
                     Data_o, FiltData_o, FiltCoeffData_o, FiltCoeffAddr_o);
        end
        Rst_i = 1'b1;
        tick();
        checks++;
        if (Ready_o !== 1'b0 || Busy_o !== 1'b0) begin
            errors++;
            $display("FAIL unconf_idle: ready=%0b busy=%0b, want 0 0", Ready_o, Busy_o);
        end
    endtask

    task automatic test_initial_load();
        for (int k = 0; k < 16; k++) begin
            CoeffWrEn_i   = 1'b1;
            CoeffWrAddr_i = 4'(k);
            CoeffWrData_i = 18'(k + 1);
            exp_shadow[k] = 18'(k + 1);
            tick();
        end
        CoeffWrEn_i = 1'b0;
        got_q.delete();
        Commit_i = 1'b1;
        tick();
        Commit_i = 1'b0;
        checks++;
        if (Busy_o !== 1'b1 || Ready_o !== 1'b0 || FiltCoeffWe_o !== 1'b1) begin
            errors++;
            $display("FAIL commit_unconf: busy=%0b ready=%0b we=%0b, want 1 0 1", Busy_o, Ready_o, FiltCoeffWe_o);
        end
        watch_reload(-1, -1);
        idle(40);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL flush_leak: %0d results seen, want 0", got_q.size());
        end
    endtask

    task automatic test_drain();
        logic [17:0] v;
        got_q.delete(); got_cyc_q.delete(); exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            v = 18'h01000 + 18'(i * 37);
            Data_i = v;
            DataNd_i = 1'b1;
            if (i == 4) Commit_i = 1'b1;
            tick();
            checks++;
            if (FiltDataNd_o !== 1'b1 || FiltData_o !== v) begin
                errors++;
                $display("FAIL fwd_%0d: nd=%0b data=%h, want 1 %h", i, FiltDataNd_o, FiltData_o, v);
            end
            exp_q.push_back(v + 18'd100);
        end
        DataNd_i = 1'b0;
        Commit_i = 1'b0;
        checks++;
        if (Ready_o !== 1'b0 || Busy_o !== 1'b1) begin
            errors++;
            $display("FAIL commit_run: ready=%0b busy=%0b, want 0 1", Ready_o, Busy_o);
        end
        watch_reload(-1, -1);
        checks++;
        if (got_q.size() != 5) begin
            errors++;
            $display("FAIL drain_count: %0d results, want 5", got_q.size());
        end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL drain_data_%0d: got %h, want %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_cyc_q.size() != 5 || load_start_cyc != got_cyc_q[4] + 1) begin
            errors++;
            $display("FAIL load_after_drain: load at %0d, last result at %0d, want last+1",
                     load_start_cyc, (got_cyc_q.size() > 0) ? got_cyc_q[got_cyc_q.size()-1] : -1);
        end
        idle(40);
    endtask

    task automatic test_commit_with_write();
        CoeffWrEn_i   = 1'b1;
        CoeffWrAddr_i = 4'd3;
        CoeffWrData_i = 18'h1FFFF;
        Commit_i      = 1'b1;
        exp_shadow[3] = 18'h1FFFF;
        tick();
        Commit_i      = 1'b0;
        CoeffWrAddr_i = 4'd5;
        CoeffWrData_i = 18'h2AAAA;
        checks++;
        if (Busy_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_commit: busy=%0b, want 1", Busy_o);
        end
        tick();
        CoeffWrEn_i = 1'b0;
        watch_reload(-1, -1);
    endtask

    task automatic test_back_to_back();
        logic [17:0] v;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            v = 18'h20000 + 18'(i * 1031);
            Data_i = v;
            DataNd_i = 1'b1;
            if (i == 39) Commit_i = 1'b1;
            tick();
            exp_q.push_back(v + 18'd100);
        end
        DataNd_i = 1'b0;
        Commit_i = 1'b0;
        watch_reload(-1, -1);
        checks++;
        if (got_q.size() != 40) begin
            errors++;
            $display("FAIL stream_count: %0d results, want 40", got_q.size());
        end
        for (int i = 0; i < 40 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stream_data_%0d: got %h, want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_drop_err();
        got_q.delete();
        Commit_i = 1'b1;
        tick();
        Commit_i = 1'b0;
        watch_reload(7, -1);
        checks++;
        if (DropErr_o !== 1'b1) begin
            errors++;
            $display("FAIL drop_sticky: DropErr_o=%0b, want 1", DropErr_o);
        end
    endtask

    task automatic test_commit_mid_flush();
        Commit_i = 1'b1;
        tick();
        Commit_i = 1'b0;
        watch_reload(-1, 10);
        idle(60);
        checks++;
        if (got_q.size() != 0 || DropErr_o !== 1'b1) begin
            errors++;
            $display("FAIL after_recommit: results=%0d drop=%0b, want 0 1", got_q.size(), DropErr_o);
        end
    endtask

    task automatic test_reset_mid_load();
        int n;
        Commit_i = 1'b1;
        tick();
        Commit_i = 1'b0;
        n = 0;
        while (FiltCoeffWe_o !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        repeat (7) tick();
        checks++;
        if (FiltCoeffWe_o !== 1'b1 || FiltCoeffAddr_o !== 4'd7) begin
            errors++;
            $display("FAIL load_cycle7: we=%0b addr=%0d, want 1 7", FiltCoeffWe_o, FiltCoeffAddr_o);
        end
        Rst_i = 1'b0;
        tick();
        checks++;
        if (FiltCoeffWe_o !== 1'b0 || Ready_o !== 1'b0 || Busy_o !== 1'b0 ||
            DropErr_o !== 1'b0 || FiltDataNd_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_load: we=%0b ready=%0b busy=%0b drop=%0b nd=%0b, want 0 0 0 0 0",
                     FiltCoeffWe_o, Ready_o, Busy_o, DropErr_o, FiltDataNd_o);
        end
        Rst_i = 1'b1;
        for (int k = 0; k < 16; k++) exp_shadow[k] = '0;
        DataNd_i = 1'b1;
        Data_i   = 18'h00777;
        tick();
        DataNd_i = 1'b0;
        checks++;
        if (DropErr_o !== 1'b1 || FiltDataNd_o !== 1'b0 || FiltCoeffWe_o !== 1'b0) begin
            errors++;
            $display("FAIL drop_unconf: drop=%0b nd=%0b we=%0b, want 1 0 0", DropErr_o, FiltDataNd_o, FiltCoeffWe_o);
        end
        for (int k = 0; k < 16; k += 2) begin
            CoeffWrEn_i   = 1'b1;
            CoeffWrAddr_i = 4'(k);
            CoeffWrData_i = 18'h15000 + 18'(k);
            exp_shadow[k] = 18'h15000 + 18'(k);
            tick();
        end
        CoeffWrEn_i = 1'b0;
        got_q.delete();
        Commit_i = 1'b1;
        tick();
        Commit_i = 1'b0;
        watch_reload(-1, -1);
        idle(40);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL reload_leak: %0d results seen, want 0", got_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_initial_load();
        test_drain();
        test_commit_with_write();
        test_back_to_back();
        test_drop_err();
        test_commit_mid_flush();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_coeff_reload_ctrl.md
Name: fir_coeff_reload_ctrl

Overview:
Sequencer in front of the systolic symmetric FIR block. It owns the filter's sample input and coefficient-write port. The host writes a shadow coefficient bank at any time and commits it. On commit the controller drains in-flight samples, copies the shadow bank into the filter, flushes the delay line with zeros, and suppresses the flush outputs. Upstream sees only Ready_o backpressure; downstream sees only clean, fully-configured results.

Parameters:
CoeffCount, 16, number of unique (symmetric) coefficients; the address width is clog2(CoeffCount).
CoeffWidth, 18, coefficient width.
DataWidth, 18, sample width at input and output.
FlushLen, 32, zero samples injected after a load; must be at least the filter delay-line length (2*CoeffCount).
MaxInFlight, 64, maximum accepted samples without outputs yet; sets the pending counter width to clog2(MaxInFlight+1).

Ports:
Clk_i  in  1  clock, all logic on the rising edge
Rst_i  in  1  reset, synchronous, active-low
Data_i  in  DataWidth  upstream sample
DataNd_i  in  1  upstream sample strobe
Ready_o  out  1  controller accepts samples this cycle
CoeffWrData_i  in  CoeffWidth  shadow bank write data
CoeffWrAddr_i  in  clog2(CoeffCount)  shadow bank write address
CoeffWrEn_i  in  1  shadow bank write enable
Commit_i  in  1  single-cycle request to apply the shadow bank
Busy_o  out  1  reconfiguration in progress
FiltData_o  out  DataWidth  sample to filter
FiltDataNd_o  out  1  sample strobe to filter
FiltCoeffData_o  out  CoeffWidth  coefficient to filter
FiltCoeffAddr_o  out  clog2(CoeffCount)  coefficient index to filter
FiltCoeffWe_o  out  1  coefficient write strobe to filter
FiltOut_i  in  DataWidth  rounded filter result
FiltOutValid_i  in  1  filter result strobe
Data_o  out  DataWidth  gated result
DataValid_o  out  1  gated result strobe
DropErr_o  out  1  sticky flag: a sample was offered while Ready_o was low

Behaviour:
- Reset (Rst_i low at an edge):
  - State goes to UNCONF.
  - All outputs go to 0, as do the pending counter, discard counter and shadow bank.
- States:
  - UNCONF: Ready_o=0, Busy_o=0.
    - Shadow writes are accepted.
    - Commit_i moves to LOAD (no drain needed).
  - RUN: Ready_o=1, Busy_o=0.
    - DataNd_i produces FiltData_o=Data_i and FiltDataNd_o=1 one cycle later, and increments the pending counter.
    - Commit_i moves to DRAIN.
    - A sample offered in the same cycle as Commit_i is still accepted.
  - DRAIN: Ready_o=0, Busy_o=1.
    - Waits until the pending counter is 0 and the discard counter is 0, then moves to LOAD.
  - LOAD: Busy_o=1; runs exactly CoeffCount cycles.
    - Each cycle drives FiltCoeffWe_o=1 with address k and shadow[k], for k=0..CoeffCount-1 in order.
    - Then moves to FLUSH and loads the discard counter with FlushLen.
  - FLUSH: Busy_o=1; runs exactly FlushLen cycles.
    - Each cycle drives FiltData_o=0 and FiltDataNd_o=1; the pending counter is not changed.
    - Then moves to RUN.
- Busy_o asserts in the cycle after the commit is accepted and deasserts on entering RUN.
- Ready_o timing:
  - Registered; it drops in the cycle after Commit_i is accepted.
  - It rises on the first RUN cycle.
- Shadow bank:
  - CoeffWrEn_i is honoured in UNCONF and RUN and ignored while Busy_o=1.
  - A write in the same cycle as an accepted Commit_i is included in the load.
  - Commit_i while Busy_o=1 is ignored; the host polls Busy_o.
- Output gating:
  - On FiltOutValid_i with discard counter > 0: the discard counter decrements and the result is dropped.
  - Otherwise Data_o=FiltOut_i and DataValid_o=1 one cycle later, and the pending counter decrements.
  - Results arrive in order, so real post-flush samples may enter while zero outputs are still being discarded.
- Simultaneous pending increment and decrement in one cycle: the counter is unchanged.
  - Counter overflow or underflow is a protocol violation and is not checked.
- DropErr_o:
  - Set on DataNd_i=1 while Ready_o=0, including in UNCONF; the sample is discarded.
  - Cleared only by reset.
- Reset mid-LOAD or mid-FLUSH:
  - Immediate return to UNCONF; no further FiltCoeffWe_o or FiltDataNd_o pulses.
  - The filter contents are then undefined until the next commit.

Decomposition:
- Shared package:
  - State enum: UNCONF, RUN, DRAIN, LOAD, FLUSH.
  - Width helpers: address width = clog2(CoeffCount); counter width = clog2(MaxInFlight+1).
  - Default CoeffWidth and DataWidth constants.
- One sub-module: fir_coeff_shadow_bank.
  - CoeffCount x CoeffWidth register file.
  - One write port and one combinational read port indexed by the LOAD counter.
  - Synchronous active-low clear.

Test Plan:
- Reset, write shadow[k]=k+1 for k=0..15, then Commit_i → 16 FiltCoeffWe_o pulses with addresses 0..15 and data 1..16, then 32 zero FiltDataNd_o pulses, then Ready_o=1; no DataValid_o for the 32 zero outputs.
- RUN with 5 samples in flight (filter latency 20), then Commit_i → Ready_o drops next cycle; the 5 real results appear on Data_o; LOAD starts the cycle after the 5th result.
- Commit_i and CoeffWrEn_i (addr 3, value 0x1FFFF) in the same cycle → the load writes 0x1FFFF at address 3.
- DataNd_i pulsed during LOAD → sample not forwarded, DropErr_o=1 and stays 1 until reset.
- Second Commit_i pulsed mid-FLUSH → ignored: exactly one LOAD sequence, Busy_o low after FlushLen cycles.
- Rst_i low at LOAD cycle 7 → FiltCoeffWe_o=0 next cycle, Ready_o=0, Busy_o=0, state UNCONF; a fresh commit performs a full 16-cycle load.
